// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: alternates one read and one write per word,
// accumulating a modulo-2^DATA_W checksum of everything it reads.
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [5:0]        length,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [5:0]        len_r;
  logic [5:0]        idx;
  logic [5:0]        idx_nxt;
  logic [DATA_W-1:0] data_r;

  assign idx_nxt = idx + 6'd1;

  // The data register only reaches the bus during WR; elsewhere the bus is quiet.
  assign mem_write_data = (state == WR) ? data_r : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      src_r       <= '0;
      dst_r       <= '0;
      len_r       <= '0;
      idx         <= '0;
      data_r      <= '0;
      checksum    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            checksum <= '0;
            idx      <= '0;
            if (length != 6'd0) begin
              src_r       <= src_addr;
              dst_r       <= dst_addr;
              len_r       <= length;
              state       <= RD;
              busy        <= 1'b1;
              mem_read    <= 1'b1;
              mem_address <= src_addr;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RD: begin
          data_r      <= mem_read_data;
          checksum    <= checksum + mem_read_data;
          mem_read    <= 1'b0;
          mem_write   <= 1'b1;
          mem_address <= dst_r + ADDR_W'(idx);
          state       <= WR;
        end
        WR: begin
          mem_write <= 1'b0;
          if (idx_nxt == len_r) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            mem_address <= '0;
          end else begin
            // Outputs are registered, so the next read address is formed from idx+1 here.
            idx         <= idx_nxt;
            state       <= RD;
            mem_read    <= 1'b1;
            mem_address <= src_r + ADDR_W'(idx_nxt);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
